// File: rtl/fp32_i2f_norm.sv
// -----------------------------------------------------------------------------
// fp32_i2f_norm
//   Three-stage pipelined int32 -> fp32 converter, round-to-nearest-even only.
//   S1 takes the magnitude, S2 normalises it using the leading-one position
//   from lzd_32b, S3 rounds and packs the fp32 word.
//   A single advance signal stalls every stage together; bubbles stay put.
//
//   Ports
//     i_clk      rising-edge clock
//     i_rst      asynchronous active-high reset
//     i_a        integer operand (signed when SIGNED_IN=1)
//     i_valid    i_a valid this cycle
//     o_ready    block accepts i_a this cycle
//     o_z        fp32 result {sign, exp[7:0], frac[22:0]}
//     o_inexact  result was rounded
//     o_valid    o_z / o_inexact valid
//     i_ready    downstream accepts o_z this cycle
// -----------------------------------------------------------------------------

// Leading-one detector: po is the bit index of the most significant set bit,
// pv flags a nonzero input (po is 0 when pv is 0).
module lzd_32b (
    input  logic [31:0] a,
    output logic [4:0]  po,
    output logic        pv
);
    // One-hot of the leading one: a bit is the leader when nothing above it is set.
    logic [31:0] above_any;
    logic [31:0] lead_oh;

    assign above_any[31] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_above
            assign above_any[gi] = above_any[gi+1] | a[gi+1];
        end
        for (gi = 0; gi < 32; gi++) begin : g_lead
            assign lead_oh[gi] = a[gi] & ~above_any[gi];
        end
    endgenerate

    always_comb begin
        po = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (lead_oh[i]) begin
                po = po | 5'(i);
            end
        end
    end

    assign pv = |a;
endmodule

module fp32_i2f_norm #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_a,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_z,
    output logic        o_inexact,
    output logic        o_valid,
    input  logic        i_ready
);
    logic adv;

    // Stage registers
    logic        s1_s_reg;
    logic [31:0] s1_m_reg;
    logic        v1_reg;
    logic        s2_s_reg;
    logic [31:0] s2_n_reg;
    logic [4:0]  s2_po_reg;
    logic        s2_pv_reg;
    logic        v2_reg;

    // Next-state values
    logic        s1_s_next;
    logic [31:0] s1_m_next;
    logic [31:0] s2_n_next;
    logic [4:0]  lz_po;
    logic        lz_pv;
    logic [22:0] frac;
    logic        g_bit;
    logic        st_bit;
    logic        rnd;
    logic [23:0] frac_sum;
    logic        carry;
    logic [7:0]  exp_next;
    logic [31:0] z_next;
    logic        inexact_next;

    // The output register is the last stage, so it frees up whenever it is
    // empty or being drained this cycle.
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    // S1: magnitude. Negating 0x80000000 wraps back to 0x80000000, which is
    // exactly the magnitude 2^31, so 32 bits suffice.
    always_comb begin
        s1_s_next = SIGNED_IN ? i_a[31] : 1'b0;
        s1_m_next = s1_s_next ? (~i_a + 32'd1) : i_a;
    end

    // S2: normalise so the leading one sits at bit 31.
    lzd_32b u_lzd (
        .a  (s1_m_reg),
        .po (lz_po),
        .pv (lz_pv)
    );

    assign s2_n_next = s1_m_reg << (5'd31 - lz_po);

    // S3: round to nearest even. A mantissa carry-out leaves frac_sum at
    // 0x800000, so the stored fraction is already zero in that case.
    always_comb begin
        frac         = s2_n_reg[30:8];
        g_bit        = s2_n_reg[7];
        st_bit       = |s2_n_reg[6:0];
        rnd          = g_bit & (st_bit | frac[0]);
        frac_sum     = {1'b0, frac} + {23'd0, rnd};
        carry        = frac_sum[23];
        exp_next     = 8'd127 + {3'd0, s2_po_reg} + {7'd0, carry};
        z_next       = s2_pv_reg ? {s2_s_reg, exp_next, frac_sum[22:0]} : 32'h0;
        inexact_next = s2_pv_reg & (g_bit | st_bit);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_s_reg  <= 1'b0;
            s1_m_reg  <= 32'h0;
            v1_reg    <= 1'b0;
            s2_s_reg  <= 1'b0;
            s2_n_reg  <= 32'h0;
            s2_po_reg <= 5'd0;
            s2_pv_reg <= 1'b0;
            v2_reg    <= 1'b0;
            o_z       <= 32'h0;
            o_inexact <= 1'b0;
            o_valid   <= 1'b0;
        end else if (adv) begin
            s1_s_reg  <= s1_s_next;
            s1_m_reg  <= s1_m_next;
            v1_reg    <= i_valid;
            s2_s_reg  <= s1_s_reg;
            s2_n_reg  <= s2_n_next;
            s2_po_reg <= lz_po;
            s2_pv_reg <= lz_pv;
            v2_reg    <= v1_reg;
            o_z       <= z_next;
            o_inexact <= inexact_next;
            o_valid   <= v2_reg;
        end
    end
endmodule

// File: tb/tb_fp32_i2f_norm.sv
// -----------------------------------------------------------------------------
// tb_fp32_i2f_norm
//   Scoreboard bench: drivers push hand-computed expectations when an operand
//   is accepted; monitors pop and compare whenever a result is transferred.
//   One signed instance carries the main stream, stall and reset scenarios;
//   an unsigned instance covers the SIGNED_IN=0 path.
// -----------------------------------------------------------------------------
module tb_fp32_i2f_norm;
    typedef struct packed {
        logic [31:0] z;
        logic        x;
        logic [31:0] a;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Signed instance
    logic [31:0] i_a = 32'h0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready;
    logic [31:0] o_z;
    logic        o_inexact;
    logic        o_valid;

    // Unsigned instance
    logic [31:0] u_a = 32'h0;
    logic        u_valid = 1'b0;
    logic        u_ready = 1'b1;
    logic        u_o_ready;
    logic [31:0] u_o_z;
    logic        u_o_inexact;
    logic        u_o_valid;

    int n_cmp  = 0;
    int n_fail = 0;
    bit u_done = 1'b0;

    exp_t exp_q[$];
    exp_t u_q[$];

    logic [31:0] va[16];
    logic [31:0] vz[16];
    logic        vx[16];
    logic [31:0] uva[5];
    logic [31:0] uvz[5];
    logic        uvx[5];

    // Monitor state
    bit          hold;
    logic [31:0] hold_z;

    always #5 clk = ~clk;

    fp32_i2f_norm #(.SIGNED_IN(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_a(i_a), .i_valid(i_valid),
        .o_ready(o_ready), .o_z(o_z), .o_inexact(o_inexact),
        .o_valid(o_valid), .i_ready(i_ready)
    );

    fp32_i2f_norm #(.SIGNED_IN(1'b0)) u_dut_u (
        .i_clk(clk), .i_rst(rst), .i_a(u_a), .i_valid(u_valid),
        .o_ready(u_o_ready), .o_z(u_o_z), .o_inexact(u_o_inexact),
        .o_valid(u_o_valid), .i_ready(u_ready)
    );

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One driver cycle: present inputs at the falling edge, then decide from
    // o_ready whether the coming rising edge accepts them.
    task automatic drive_cycle(input logic v, input int idx, input logic r, output bit acc);
        exp_t e;
        @(negedge clk);
        i_valid = v;
        i_a     = v ? va[idx] : 32'h0;
        i_ready = r;
        #1;
        acc = v && o_ready;
        if (acc) begin
            e.z = vz[idx]; e.x = vx[idx]; e.a = va[idx];
            exp_q.push_back(e);
            $display("in  a=%h expect z=%h inexact=%0b", va[idx], vz[idx], vx[idx]);
        end
    endtask

    // Stream vectors lo..hi-1; i_ready is low for 3 cycles starting at stall_at.
    task automatic stream(input int lo, input int hi, input int stall_at);
        int idx = lo;
        int cyc = 0;
        bit acc;
        logic r;
        while (idx < hi && cyc < 200) begin
            r = !(cyc >= stall_at && cyc < stall_at + 3);
            drive_cycle(1'b1, idx, r, acc);
            if (acc) idx++;
            cyc++;
        end
        if (idx < hi) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_timeout: accepted %0d, expected %0d", idx - lo, hi - lo);
        end
        drive_cycle(1'b0, 0, 1'b1, acc);
    endtask

    // Signed-instance monitor
    initial begin
        exp_t e;
        hold = 1'b0;
        hold_z = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check1("stall_hold_z", o_z, hold_z);
                    check1("stall_hold_valid", {31'd0, o_valid}, 32'd1);
                end
                if (o_valid && !i_ready) begin
                    check1("stall_o_ready", {31'd0, o_ready}, 32'd0);
                    hold = 1'b1;
                    hold_z = o_z;
                end else begin
                    hold = 1'b0;
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_output: got z=%h, expected none", o_z);
                    end else begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (o_z !== e.z || o_inexact !== e.x) begin
                            n_fail++;
                            $display("FAIL result a=%h: got z=%h inexact=%0b, expected z=%h inexact=%0b",
                                     e.a, o_z, o_inexact, e.z, e.x);
                        end else begin
                            $display("out a=%h z=%h inexact=%0b ok", e.a, o_z, o_inexact);
                        end
                    end
                end
            end
        end
    end

    // Unsigned-instance monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && u_o_valid && u_ready) begin
                if (u_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL u_unexpected_output: got z=%h, expected none", u_o_z);
                end else begin
                    e = u_q.pop_front();
                    n_cmp++;
                    if (u_o_z !== e.z || u_o_inexact !== e.x) begin
                        n_fail++;
                        $display("FAIL u_result a=%h: got z=%h inexact=%0b, expected z=%h inexact=%0b",
                                 e.a, u_o_z, u_o_inexact, e.z, e.x);
                    end else begin
                        $display("out(u) a=%h z=%h inexact=%0b ok", e.a, u_o_z, u_o_inexact);
                    end
                end
            end
        end
    end

    // Unsigned-instance driver
    initial begin
        exp_t e;
        int tries;
        uva[0] = 32'hFFFFFFFF; uvz[0] = 32'h4F800000; uvx[0] = 1'b1;
        uva[1] = 32'h80000000; uvz[1] = 32'h4F000000; uvx[1] = 1'b0;
        uva[2] = 32'h00000001; uvz[2] = 32'h3F800000; uvx[2] = 1'b0;
        uva[3] = 32'h00000000; uvz[3] = 32'h00000000; uvx[3] = 1'b0;
        uva[4] = 32'hFFFFFF00; uvz[4] = 32'h4F7FFFFF; uvx[4] = 1'b0;
        wait (rst == 1'b0);
        for (int k = 0; k < 5; k++) begin
            tries = 0;
            do begin
                @(negedge clk);
                u_a = uva[k];
                u_valid = 1'b1;
                #1;
                tries++;
            end while (!u_o_ready && tries < 20);
            if (u_o_ready) begin
                e.z = uvz[k]; e.x = uvx[k]; e.a = uva[k];
                u_q.push_back(e);
                $display("in(u) a=%h expect z=%h inexact=%0b", uva[k], uvz[k], uvx[k]);
            end else begin
                n_cmp++; n_fail++;
                $display("FAIL u_accept_timeout: o_ready=%0b, expected 1", u_o_ready);
            end
        end
        @(negedge clk);
        u_valid = 1'b0;
        u_done = 1'b1;
    end

    // Main sequence
    initial begin
        bit acc;
        int lat;
        va[0]  = 32'h00000001; vz[0]  = 32'h3F800000; vx[0]  = 1'b0;
        va[1]  = 32'h00000000; vz[1]  = 32'h00000000; vx[1]  = 1'b0;
        va[2]  = 32'hFFFFFFFF; vz[2]  = 32'hBF800000; vx[2]  = 1'b0;
        va[3]  = 32'h7FFFFFFF; vz[3]  = 32'h4F000000; vx[3]  = 1'b1;
        va[4]  = 32'h80000000; vz[4]  = 32'hCF000000; vx[4]  = 1'b0;
        va[5]  = 32'h01000001; vz[5]  = 32'h4B800000; vx[5]  = 1'b1;
        va[6]  = 32'h01000003; vz[6]  = 32'h4B800002; vx[6]  = 1'b1;
        va[7]  = 32'h00FFFFFF; vz[7]  = 32'h4B7FFFFF; vx[7]  = 1'b0;
        va[8]  = 32'h12345678; vz[8]  = 32'h4D91A2B4; vx[8]  = 1'b1;
        va[9]  = 32'h7FFFFFC0; vz[9]  = 32'h4F000000; vx[9]  = 1'b1;
        va[10] = 32'h7FFFFF40; vz[10] = 32'h4EFFFFFE; vx[10] = 1'b1;
        va[11] = 32'hFFFFFFFB; vz[11] = 32'hC0A00000; vx[11] = 1'b0;
        va[12] = 32'h00000064; vz[12] = 32'h42C80000; vx[12] = 1'b0;
        va[13] = 32'hFEFFFFFF; vz[13] = 32'hCB800000; vx[13] = 1'b1;
        va[14] = 32'h01000002; vz[14] = 32'h4B800001; vx[14] = 1'b0;
        va[15] = 32'h00000003; vz[15] = 32'h40400000; vx[15] = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check1("reset_o_valid", {31'd0, o_valid}, 32'd0);
        check1("reset_o_z", o_z, 32'h0);
        check1("reset_o_inexact", {31'd0, o_inexact}, 32'd0);
        #2;
        rst = 1'b0;

        // Back-to-back stream with full downstream readiness
        stream(0, 16, -10);
        // Stream with a 3-cycle downstream stall mid-way
        stream(0, 8, 3);

        // Let everything drain before the reset scenario
        for (int k = 0; k < 20 && (exp_q.size() != 0 || !u_done || u_q.size() != 0); k++)
            @(negedge clk);

        // Asynchronous reset with three operands in flight
        drive_cycle(1'b1, 8, 1'b1, acc);
        drive_cycle(1'b1, 9, 1'b1, acc);
        drive_cycle(1'b1, 10, 1'b1, acc);
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check1("async_rst_o_valid", {31'd0, o_valid}, 32'd0);
        check1("async_rst_o_z", o_z, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #3;
        rst = 1'b0;

        // Latency of the first operand after release
        drive_cycle(1'b1, 15, 1'b1, acc);
        check1("post_rst_accept", {31'd0, acc}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            if (o_valid) lat = k;
        end
        check1("post_rst_latency", lat, 32'd3);

        // Final drain
        for (int k = 0; k < 20 && (exp_q.size() != 0 || u_q.size() != 0); k++)
            @(negedge clk);
        check1("drain_signed", exp_q.size(), 32'd0);
        check1("drain_unsigned", u_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end
endmodule
